// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider.
// Operands A and B are loaded from a shared bus. A start pulse snapshots them
// and produces one quotient bit per clock. Quotient and remainder are reported
// together with a one-cycle done pulse. When B is zero the divider skips the
// iterations and reports quotient = all ones, remainder = A and div_by_zero.
module seq_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load_a,
    input  logic             load_b,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic [WIDTH-1:0] op_a,
    output logic [WIDTH-1:0] op_b
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    // S_ZERO is the single non-busy cycle that publishes a divide-by-zero result
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam logic [1:0] S_ZERO = 2'd3;

    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    logic [1:0]       state_q,     state_d;
    logic [WIDTH-1:0] a_q,         a_d;
    logic [WIDTH-1:0] b_q,         b_d;
    // dvd_q shifts dividend bits out of its MSB and quotient bits into its LSB
    logic [WIDTH-1:0] dvd_q,       dvd_d;
    logic [WIDTH-1:0] dvs_q,       dvs_d;
    logic [WIDTH-1:0] rem_q,       rem_d;
    logic [CW-1:0]    cnt_q,       cnt_d;
    logic [WIDTH-1:0] quotient_q,  quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             dbz_q,       dbz_d;

    // One restoring step: the shifted partial remainder is WIDTH+1 bits wide
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   rem_diff;
    logic             q_bit;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] quo_next;

    // Restoring iteration datapath
    always_comb begin
        rem_shift = {rem_q, dvd_q[WIDTH-1]};
        rem_diff  = rem_shift - {1'b0, dvs_q};
        // A set top bit means rem_shift already exceeds any WIDTH-bit divisor;
        // otherwise bit WIDTH of the difference is the borrow.
        q_bit     = rem_shift[WIDTH] | ~rem_diff[WIDTH];
        rem_next  = q_bit ? rem_diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
        quo_next  = {dvd_q[WIDTH-2:0], q_bit};
    end

    // Next-state logic for the FSM, operand registers and result registers
    always_comb begin
        // NOTE: every register defaults to its current value so no path through
        // the case statement leaves a signal unassigned and infers a latch.
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        dvd_d       = dvd_q;
        dvs_d       = dvs_q;
        rem_d       = rem_q;
        cnt_d       = cnt_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;

        // Operand loads happen in any state; the working copies are separate
        if (load_a) a_d = data_in;
        if (load_b) b_d = data_in;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    dvd_d   = a_q;
                    dvs_d   = b_q;
                    rem_d   = '0;
                    cnt_d   = '0;
                    state_d = (b_q == '0) ? S_ZERO : S_CALC;
                end
            end
            S_CALC: begin
                dvd_d = quo_next;
                rem_d = rem_next;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_BIT) begin
                    quotient_d  = quo_next;
                    remainder_d = rem_next;
                    dbz_d       = 1'b0;
                    state_d     = S_DONE;
                end
            end
            S_ZERO: begin
                quotient_d  = '1;
                remainder_d = dvd_q;
                dbz_d       = 1'b1;
                state_d     = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            dvd_q       <= '0;
            dvs_q       <= '0;
            rem_q       <= '0;
            cnt_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so all registers update from the
            // same pre-edge values regardless of statement order.
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            dvd_q       <= dvd_d;
            dvs_q       <= dvs_d;
            rem_q       <= rem_d;
            cnt_q       <= cnt_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    assign busy        = (state_q == S_CALC);
    assign done        = (state_q == S_DONE);
    assign div_by_zero = dbz_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign op_a        = a_q;
    assign op_b        = b_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed self-checking bench for seq_divider (WIDTH = 8).
module tb_seq_divider;

    localparam int W = 8;

    logic         clk;
    logic         resetn;
    logic [W-1:0] data_in;
    logic         load_a;
    logic         load_b;
    logic         start;
    logic         busy;
    logic         done;
    logic         div_by_zero;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;

    int n_assert = 0;
    int n_fail   = 0;

    seq_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .data_in     (data_in),
        .load_a      (load_a),
        .load_b      (load_b),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .quotient    (quotient),
        .remainder   (remainder),
        .op_a        (op_a),
        .op_b        (op_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_assert++;
        assert (observed === expected) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Advance past one rising edge; inputs change and outputs are sampled 1ns later
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_ops(input logic [W-1:0] a, input logic [W-1:0] b);
        data_in = a; load_a = 1'b1; load_b = 1'b0;
        step();
        data_in = b; load_a = 1'b0; load_b = 1'b1;
        step();
        load_b = 1'b0;
    endtask

    // Start a division and wait (bounded) for done; check latency, busy cycles, results
    task automatic run_div(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                           input int eq, input int er, input int edbz,
                           input int elat, input int ebusy);
        int edges;
        int busy_cnt;
        load_ops(a, b);
        start = 1'b1;
        step();                       // edge k
        start = 1'b0;
        edges = 0;
        busy_cnt = 0;
        while (done !== 1'b1 && edges < 40) begin
            if (busy === 1'b1) busy_cnt++;
            step();
            edges++;
        end
        check({tag, "_latency"}, edges, elat);
        check({tag, "_busy_cycles"}, busy_cnt, ebusy);
        check({tag, "_q"}, quotient, eq);
        check({tag, "_r"}, remainder, er);
        check({tag, "_dbz"}, div_by_zero, edbz);
        step();
        check({tag, "_done_one_cycle"}, done, 0);
        check({tag, "_q_hold"}, quotient, eq);
    endtask

    initial begin
        int edges;
        int done_cnt;
        int first_done;
        int second_done;

        resetn  = 1'b0;
        data_in = '0;
        load_a  = 1'b0;
        load_b  = 1'b0;
        start   = 1'b0;
        #12;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_dbz", div_by_zero, 0);
        check("rst_q", quotient, 0);
        check("rst_r", remainder, 0);
        check("rst_op_a", op_a, 0);
        check("rst_op_b", op_b, 0);
        resetn = 1'b1;
        step();

        // Basic divisions and boundary operands
        run_div("d200_7",   8'd200, 8'd7,   28,  4,  0, 8, 8);
        run_div("d255_1",   8'd255, 8'd1,   255, 0,  0, 8, 8);
        run_div("d5_9",     8'd5,   8'd9,   0,   5,  0, 8, 8);
        run_div("d255_255", 8'd255, 8'd255, 1,   0,  0, 8, 8);
        // Divide by zero: no CALC cycles, done after edge k+1
        run_div("d77_0",    8'd77,  8'd0,   255, 77, 1, 1, 0);
        // A normal division afterwards clears div_by_zero
        run_div("d13_4",    8'd13,  8'd4,   3,   1,  0, 8, 8);

        // Load and start during CALC: in-flight result unaffected, start ignored
        load_ops(8'd100, 8'd10);
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        data_in = 8'd3; load_a = 1'b1; start = 1'b1;
        step();
        load_a = 1'b0; start = 1'b0;
        check("calc_load_op_a", op_a, 3);
        check("calc_busy", busy, 1);
        edges = 3;
        done_cnt = 0;
        while (edges < 14) begin
            if (done === 1'b1) done_cnt++;
            step();
            edges++;
        end
        check("calc_load_done_count", done_cnt, 1);
        check("calc_load_q", quotient, 10);
        check("calc_load_r", remainder, 0);
        check("calc_load_idle", busy, 0);

        // start and load_b on the same edge: division uses old B (A=3, B=10)
        data_in = 8'd4; load_b = 1'b1; start = 1'b1;
        step();
        load_b = 1'b0; start = 1'b0;
        check("snap_op_b", op_b, 4);
        edges = 0;
        while (done !== 1'b1 && edges < 40) begin
            step();
            edges++;
        end
        check("snap_latency", edges, 8);
        check("snap_q", quotient, 0);
        check("snap_r", remainder, 3);
        step();

        // Reset asserted in CALC with count = 4
        load_ops(8'd200, 8'd7);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 4; i++) step();
        check("abort_busy_before", busy, 1);
        resetn = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_q", quotient, 0);
        check("abort_r", remainder, 0);
        check("abort_op_a", op_a, 0);
        check("abort_op_b", op_b, 0);
        step();
        resetn = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (done === 1'b1) done_cnt++;
            step();
        end
        check("abort_no_done", done_cnt, 0);
        check("abort_q_after", quotient, 0);
        run_div("fresh_200_7", 8'd200, 8'd7, 28, 4, 0, 8, 8);

        // Back-to-back with start held: second division accepted at edge k+10
        // and uses operands loaded during the first (100 / 9 = 11 r 1)
        data_in = 8'd200; load_a = 1'b1;
        step();
        data_in = 8'd7; load_a = 1'b0; load_b = 1'b1;
        step();
        load_b = 1'b0;
        start = 1'b1;
        step();                                // edge k
        data_in = 8'd100; load_a = 1'b1;
        step();                                // edge k+1
        data_in = 8'd9; load_a = 1'b0; load_b = 1'b1;
        step();                                // edge k+2
        load_b = 1'b0;
        edges = 2;
        done_cnt = 0;
        first_done = -1;
        second_done = -1;
        while (edges < 19) begin
            step();
            edges++;
            if (done === 1'b1) begin
                done_cnt++;
                if (first_done < 0) first_done = edges;
                else second_done = edges;
            end
            if (edges == 12) begin
                check("b2b_q_stable", quotient, 28);
                check("b2b_r_stable", remainder, 4);
                check("b2b_second_busy", busy, 1);
            end
        end
        start = 1'b0;
        check("b2b_done_count", done_cnt, 2);
        check("b2b_first_done_edge", first_done, 8);
        check("b2b_second_done_edge", second_done, 18);
        check("b2b_q2", quotient, 11);
        check("b2b_r2", remainder, 1);
        step();
        step();
        check("b2b_idle", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
